// File: rtl/data_mem_ctrl.sv
// Load/store controller between the MEM stage and a byte-addressed, one-cycle-latency data RAM.
// Checks alignment, maps byte lanes big-endian, and returns extended load data or an error.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_cs,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic                  sgn;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                          state, state_nxt;
  req_t                            req_q;
  logic                            req_err;
  logic [NUM_LANES-1:0][7:0]       wdata_swap;
  logic [DATA_WIDTH-1:0]           st_word;
  logic [NUM_LANES-1:0]            st_be;
  logic [4:0]                      st_shift;
  logic [DATA_WIDTH-1:0]           ld_data;

  assign req_err = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // Full byte reverse, then shift down so the MSB-first bytes of a short store land from lane 0 up.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wdata_swap[i] = req_q.wdata[8*(NUM_LANES-1-i) +: 8];
  end

  always_comb begin
    st_be    = '1;
    st_shift = 5'd0;
    unique case (req_q.size)
      2'b00:   begin st_be = 4'b0001; st_shift = 5'd24; end
      2'b01:   begin st_be = 4'b0011; st_shift = 5'd16; end
      default: begin st_be = 4'b1111; st_shift = 5'd0;  end
    endcase
  end

  assign st_word = wdata_swap >> st_shift;

  // The RAM presents mem[addr] on the top byte, so short loads come from the high end.
  always_comb begin
    unique case (req_q.size)
      2'b00:   ld_data = {{24{req_q.sgn & ram_rdata[31]}}, ram_rdata[31:24]};
      2'b01:   ld_data = {{16{req_q.sgn & ram_rdata[31]}}, ram_rdata[31:16]};
      default: ld_data = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = req_err ? RESP : ACCESS;
      ACCESS:  state_nxt = req_q.we ? RESP : CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state)
      IDLE:   req_ready = 1'b1;
      ACCESS: begin
        ram_cs   = 1'b1;
        ram_addr = req_q.addr;
        if (req_q.we) begin
          ram_we    = st_be;
          ram_wdata = st_word;
        end
      end
      RESP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      req_q     <= '{we: req_we, size: req_size, sgn: req_signed, addr: req_addr, wdata: req_wdata};
      rsp_rdata <= '0;
      rsp_err   <= req_err;
    end else if (state == CAPTURE) begin
      rsp_rdata <= ld_data;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte-array RAM model, reference memory with big-endian load/store rules,
// per-cycle response scoreboard, and directed vectors with literal expectations from the test plan.
module tb_data_mem_ctrl;
  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          ram_cs;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;

  int checks = 0, fails = 0, cs_cnt = 0;
  logic [32:0] expq[$];

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // RAM model: lane i writes mem[addr+i]; reads are registered and return 0 once cs drops.
  logic [7:0] mem [0:255];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = '0, pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (ram_cs)
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[ram_addr[7:0] + 8'(i)] <= ram_wdata[8*i +: 8];
    ram_rdata <= ram_cs ? {mem[ram_addr[7:0]], mem[ram_addr[7:0] + 8'd1],
                           mem[ram_addr[7:0] + 8'd2], mem[ram_addr[7:0] + 8'd3]} : 32'd0;
  end

  logic [7:0] ref_mem [0:255];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_cs) cs_cnt++;
      else chk("ram_bus_quiet", {31'b0, (ram_we != 0) || (ram_addr != 0) || (ram_wdata != 0)}, 32'd0);
      if (rsp_valid) begin
        if (expq.size() == 0) chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
        else begin
          chk("rsp_rdata", rsp_rdata, expq[0][31:0]);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, expq[0][32]});
          if (rsp_ready) void'(expq.pop_front());
        end
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      pl_en   = 1'b1;
      pl_addr = a + 8'(k);
      pl_data = w[31-8*k -: 8];
      ref_mem[a + 8'(k)] = w[31-8*k -: 8];
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
  endtask

  // lit: expected rsp_rdata for loads, expected ram_wdata in ACCESS for stores.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input logic [AW-1:0] a,
                        input logic [31:0] wd, input int bp, input logic chk_lit, input logic [31:0] lit);
    logic err;
    int n, nb, c0;
    logic [63:0] v;
    logic [31:0] expw;
    nb  = 1 << sz;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    rsp_ready = (bp == 0);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    v = 64'd0;
    if (!err && !we) begin
      for (int k = 0; k < nb; k++) v = (v << 8) | 64'(ref_mem[a[7:0] + 8'(k)]);
      if (sg && sz != 2'd2 && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
    end
    expq.push_back({err, (err || we) ? 32'd0 : v[31:0]});
    c0 = cs_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!err && we) begin
      expw = '0;
      for (int k = 0; k < nb; k++) expw[8*k +: 8] = wd[8*(nb-1-k) +: 8];
      chk("st_we", {28'b0, ram_we}, (32'd1 << nb) - 32'd1);
      chk("st_wdata", ram_wdata, expw);
      chk("st_addr", 32'(ram_addr), 32'(a));
      if (chk_lit) chk("st_wdata_lit", ram_wdata, lit);
    end
    n = 1;
    while (!rsp_valid && n < 8) begin @(posedge clk); #1; n++; end
    chk("latency", n, err ? 32'd1 : (we ? 32'd2 : 32'd3));
    if (!we && chk_lit) chk("ld_lit", rsp_rdata, lit);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {30'b0, rsp_valid, req_ready}, 32'd2);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_done", {30'b0, rsp_valid, req_ready}, 32'd1);
    chk("cs_cycles", cs_cnt - c0, err ? 32'd0 : 32'd1);
    if (!err && we)
      for (int k = 0; k < nb; k++) ref_mem[a[7:0] + 8'(k)] = wd[8*(nb-1-k) +: 8];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preload(8'h10, 32'h81223344);
    preload(8'h20, 32'h00000000);
    preload(8'h30, 32'h0BADF00D);
    #1;
    chk("rst_ready_valid", {30'b0, req_ready, rsp_valid}, 32'd2);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_ram", {27'b0, rsp_err, ram_cs, ram_we != 0, ram_addr != 0, ram_wdata != 0}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b0, 2'd2, 1'b0, 30'h10, 32'h0, 0, 1'b1, 32'h81223344);
    do_req(1'b0, 2'd0, 1'b1, 30'h10, 32'h0, 0, 1'b1, 32'hFFFFFF81);
    do_req(1'b0, 2'd0, 1'b0, 30'h10, 32'h0, 0, 1'b1, 32'h00000081);
    do_req(1'b0, 2'd1, 1'b1, 30'h12, 32'h0, 0, 1'b1, 32'h00003344);
    do_req(1'b0, 2'd1, 1'b0, 30'h10, 32'h0, 0, 1'b1, 32'h00008122);
    do_req(1'b0, 2'd1, 1'b1, 30'h10, 32'h0, 0, 1'b1, 32'hFFFF8122);
    do_req(1'b0, 2'd0, 1'b1, 30'h13, 32'h0, 0, 1'b1, 32'h00000044);

    do_req(1'b1, 2'd2, 1'b0, 30'h20, 32'hDEADBEEF, 0, 1'b1, 32'hEFBEADDE);
    do_req(1'b0, 2'd2, 1'b0, 30'h20, 32'h0, 0, 1'b1, 32'hDEADBEEF);
    do_req(1'b1, 2'd1, 1'b0, 30'h22, 32'h0000CAFE, 0, 1'b1, 32'h0000FECA);
    do_req(1'b0, 2'd2, 1'b0, 30'h20, 32'h0, 0, 1'b1, 32'hDEADCAFE);
    do_req(1'b1, 2'd0, 1'b0, 30'h21, 32'h000000AA, 0, 1'b1, 32'h000000AA);
    do_req(1'b0, 2'd2, 1'b0, 30'h20, 32'h0, 0, 1'b1, 32'hDEAACAFE);

    do_req(1'b0, 2'd2, 1'b0, 30'h22, 32'h0, 0, 1'b0, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 30'h23, 32'h11112222, 0, 1'b0, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 30'h20, 32'h55555555, 0, 1'b0, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 30'h20, 32'h0, 0, 1'b1, 32'hDEAACAFE);

    do_req(1'b0, 2'd2, 1'b0, 30'h10, 32'h0, 5, 1'b1, 32'h81223344);

    // Reset during the ACCESS cycle of a store: the write strobe must vanish before the next edge.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 30'h30; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid_cs_before", {31'b0, ram_cs}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ram", {28'b0, ram_cs, ram_we != 0, ram_addr != 0, ram_wdata != 0}, 32'd0);
    chk("rst_mid_handshake", {30'b0, req_ready, rsp_valid}, 32'd2);
    chk("rst_mid_rsp", {rsp_rdata[30:0], rsp_err}, 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 2'd2, 1'b0, 30'h30, 32'h0, 0, 1'b1, 32'h0BADF00D);

    chk("queue_drained", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end
endmodule
